apb_requester_bridge: RTL and testbench

- Parametrised APB4 requester that turns a valid/ready command stream into APB transfers on a shared bus fanned out to NUM_SLAVES completers.
- Next generation of the bench-side APB interface: widths, completer count and write strobes are configurable.
- Adds address decode, wait-state handling, decode-error and bus-error reporting, and a response channel with backpressure.
- Sits between a DMA or test sequencer and the APB peripheral subsystem.

---
 rtl/apb_requester_bridge_if.sv | 69 ++++++
 rtl/apb_requester_bridge.sv | 264 ++++++++++++++++++++++++++
 tb/tb_apb_requester_bridge.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_requester_bridge_if
//
// Purpose:
//   Groups the signals of the APB requester bridge into one bundle. The
//   bundle has three parts: the command stream (valid/ready), the response
//   stream (valid/ready) and the shared APB4 bus.
//
// Modports:
//   master : the bridge side. It takes commands, returns responses and
//            drives the APB request signals.
//   slave  : the system side. This is the command source, the response sink
//            and the APB completers.
//
// Signal summary:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_strb : command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                     : response channel
//   PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE                    : APB request
//   PRDATA/PREADY/PSLVERR : per-completer APB return signals. Completer i
//                           uses PRDATA[i*DATA_WIDTH +: DATA_WIDTH].
// ---------------------------------------------------------------------------
interface apb_requester_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  // command channel
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic                             cmd_write;
  logic [ADDR_WIDTH-1:0]            cmd_addr;
  logic [DATA_WIDTH-1:0]            cmd_wdata;
  logic [DATA_WIDTH/8-1:0]          cmd_strb;

  // response channel
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             rsp_err;

  // APB bus
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [DATA_WIDTH/8-1:0]          PSTRB;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_requester_bridge.sv
// ---------------------------------------------------------------------------
// apb_requester_bridge
//
// Purpose:
//   APB4 requester. It turns a valid/ready command stream into APB transfers
//   on a shared bus that fans out to NUM_SLAVES completers. Each completer
//   owns a 2**SLAVE_AW byte window, and the windows are stacked from
//   address 0. Only one transfer is outstanding at a time. Each transfer
//   returns exactly one response on the response channel. The response
//   channel supports backpressure.
//
// Ports:
//   PCLK   : clock; all state changes on its rising edge
//   RESET  : synchronous, active-high reset. Any in-flight transfer is
//            abandoned and produces no response.
//   bus    : apb_requester_bridge_if.master. It carries the command channel,
//            the response channel and the APB bus.
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH (8/16/32), NUM_SLAVES (1..16), SLAVE_AW,
//   TIMEOUT_CYCLES (ACCESS-phase limit, used only with the option below)
//
// Build option:
//   APB_REQ_TIMEOUT_EN - When defined, ACCESS is abandoned with an error
//                        after TIMEOUT_CYCLES cycles without PREADY. When
//                        undefined, ACCESS waits for PREADY indefinitely.
// ---------------------------------------------------------------------------
module apb_requester_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLAVE_AW       = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   PCLK,
  input  logic                   RESET,
  apb_requester_bridge_if.master bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  // Elaboration-time checks on the parameter ranges.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
    $error("apb_requester_bridge: DATA_WIDTH must be 8, 16 or 32");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("apb_requester_bridge: NUM_SLAVES must be 1..16");
  end
  if (SLAVE_AW + IDX_W > ADDR_WIDTH) begin : g_bad_slave_aw
    $error("apb_requester_bridge: SLAVE_AW too large for ADDR_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_requester_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  write_reg, write_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0]     strb_reg, strb_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  err_reg, err_next;
  logic                  ready_reg, ready_next;

  // -------------------------------------------------------------------------
  // Address decode.
  // The whole field above the completer window is compared against
  // NUM_SLAVES, not just the index bits. Addresses above the last window
  // therefore report a decode error instead of aliasing onto a lower
  // completer.
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] cmd_window;
  logic                  cmd_hit;
  logic [IDX_W-1:0]      cmd_idx;

  assign cmd_window = bus.cmd_addr >> SLAVE_AW;
  assign cmd_hit    = (cmd_window < ADDR_WIDTH'(NUM_SLAVES));
  // With NUM_SLAVES = 1, cmd_hit already forces this bit to 0.
  assign cmd_idx    = bus.cmd_addr[SLAVE_AW +: IDX_W];

  // -------------------------------------------------------------------------
  // Completer return-path selection.
  // idx_onehot is a one-hot mask of the latched completer index. It masks
  // PREADY and PSLVERR, so unselected completers cannot affect the transfer.
  // It also steers the PRDATA slice into the capture register.
  // -------------------------------------------------------------------------
  logic [NUM_SLAVES-1:0] idx_onehot;
  logic [DATA_WIDTH-1:0] prdata_masked [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] prdata_sel;
  logic                  pready_sel;
  logic                  pslverr_sel;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign idx_onehot[gi]    = (idx_reg == IDX_W'(gi));
    assign prdata_masked[gi] = idx_onehot[gi] ? bus.PRDATA[gi*DATA_WIDTH +: DATA_WIDTH]
                                              : '0;
  end

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      prdata_sel = prdata_sel | prdata_masked[i];
    end
  end

  assign pready_sel  = |(bus.PREADY  & idx_onehot);
  assign pslverr_sel = |(bus.PSLVERR & idx_onehot);

  // -------------------------------------------------------------------------
  // Optional ACCESS-phase timeout.
  // The counter is cleared in SETUP, so it starts at 0 on the first ACCESS
  // cycle. tmo_hit marks the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
  // The FSM tests PREADY first, so a completer that answers on that very
  // cycle still completes normally.
  // -------------------------------------------------------------------------
`ifdef APB_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if (state_reg == SETUP) begin
      tmo_cnt_next = '0;
    end else if (state_reg == ACCESS && !pready_sel) begin
      tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state and datapath next values.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    wdata_next = wdata_reg;
    strb_next  = strb_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    ready_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // ready_reg (not a state decode) gates acceptance. This keeps
        // cmd_ready low for the first cycle after reset.
        if (bus.cmd_valid && ready_reg) begin
          addr_next  = bus.cmd_addr;
          write_next = bus.cmd_write;
          wdata_next = bus.cmd_wdata;
          strb_next  = bus.cmd_write ? bus.cmd_strb : '0;
          idx_next   = cmd_idx;
          rdata_next = '0;
          err_next   = 1'b0;
          if (cmd_hit) begin
            state_next = SETUP;
          end else begin
            state_next = RESP;
            err_next   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_next = ACCESS;
      end

      ACCESS: begin
        if (pready_sel) begin
          rdata_next = write_reg ? '0 : prdata_sel;
          err_next   = pslverr_sel;
          state_next = RESP;
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (tmo_hit) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end
`endif
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // cmd_ready is registered so that it reads 0 throughout reset.
    ready_next = (state_next == IDLE);
  end

  // -------------------------------------------------------------------------
  // State and datapath registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      wdata_reg <= wdata_next;
      strb_reg  <= strb_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      ready_reg <= ready_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs.
  // The request fields come straight from the registers. They therefore stay
  // stable from SETUP through the end of ACCESS, and hold in IDLE/RESP.
  // -------------------------------------------------------------------------
  assign bus.cmd_ready = ready_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

  assign bus.PADDR   = addr_reg;
  assign bus.PWRITE  = write_reg;
  assign bus.PWDATA  = wdata_reg;
  assign bus.PSTRB   = strb_reg;
  assign bus.PSEL    = (state_reg == SETUP || state_reg == ACCESS) ? idx_onehot : '0;
  assign bus.PENABLE = (state_reg == ACCESS);

endmodule

// File: tb/tb_apb_requester_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_requester_bridge
//
// Directed bench for apb_requester_bridge. It uses NUM_SLAVES = 4,
// SLAVE_AW = 12 and TIMEOUT_CYCLES = 8. Inputs are driven on the falling
// clock edge. Outputs are sampled on the falling edge, before new inputs are
// driven. The comments on each step give the cycle relative to the
// accepting edge N.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_requester_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic PCLK;
  logic RESET;

  int pass_cnt;
  int total_cnt;

  apb_requester_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  apb_requester_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .SLAVE_AW(12), .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK  (PCLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    $display("txn %s addr=%08h wdata=%08h strb=%h", wr ? "WR" : "RD", addr, wdata, strb);
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    RESET         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = {32'hCAFE0003, 32'h12345678, 32'hBBBB0001, 32'hAAAA0000};
    bus.PREADY    = 4'b1111;
    bus.PSLVERR   = 4'b0000;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_psel",      64'(bus.PSEL),      64'd0);
    chk("rst_penable",   64'(bus.PENABLE),   64'd0);
    chk("rst_paddr",     64'(bus.PADDR),     64'd0);
    RESET = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // ---- 1: zero-wait write to completer 0 ----
    send(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
    tick();                                  // N+1: SETUP
    bus.cmd_valid = 1'b0;
    chk("w0_setup_psel",    64'(bus.PSEL),      64'b0001);
    chk("w0_setup_penable", 64'(bus.PENABLE),   64'd0);
    chk("w0_setup_paddr",   64'(bus.PADDR),     64'h10);
    chk("w0_setup_pwrite",  64'(bus.PWRITE),    64'd1);
    chk("w0_setup_pwdata",  64'(bus.PWDATA),    64'hDEADBEEF);
    chk("w0_setup_pstrb",   64'(bus.PSTRB),     64'hF);
    chk("w0_setup_ready",   64'(bus.cmd_ready), 64'd0);
    tick();                                  // N+2: ACCESS
    chk("w0_access_psel",    64'(bus.PSEL),      64'b0001);
    chk("w0_access_penable", 64'(bus.PENABLE),   64'd1);
    chk("w0_access_rspv",    64'(bus.rsp_valid), 64'd0);
    tick();                                  // N+3: RESP
    chk("w0_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("w0_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("w0_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("w0_rsp_psel",  64'(bus.PSEL),      64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("w0_done_rspv",  64'(bus.rsp_valid), 64'd0);
    chk("w0_done_ready", 64'(bus.cmd_ready), 64'd1);

    // ---- 2: read completer 2 with 3 wait states; others ready, slice 3 erroring ----
    bus.PREADY  = 4'b1011;
    bus.PSLVERR = 4'b1000;
    send(1'b0, 32'h0000_2004, 32'h55AA55AA, 4'hF);
    tick();                                  // N+1: SETUP
    bus.cmd_valid = 1'b0;
    chk("r2_setup_psel",   64'(bus.PSEL),   64'b0100);
    chk("r2_setup_pstrb",  64'(bus.PSTRB),  64'd0);
    chk("r2_setup_pwrite", 64'(bus.PWRITE), 64'd0);
    chk("r2_setup_pwdata", 64'(bus.PWDATA), 64'h55AA55AA);
    tick();                                  // N+2: first ACCESS
    for (int i = 0; i < 3; i++) begin        // N+2..N+4: waits
      chk("r2_wait_penable", 64'(bus.PENABLE),   64'd1);
      chk("r2_wait_psel",    64'(bus.PSEL),      64'b0100);
      chk("r2_wait_paddr",   64'(bus.PADDR),     64'h2004);
      chk("r2_wait_rspv",    64'(bus.rsp_valid), 64'd0);
      tick();
    end
    bus.PREADY = 4'b1111;                    // N+5: completer ready
    chk("r2_last_penable", 64'(bus.PENABLE), 64'd1);
    tick();                                  // N+6: RESP
    chk("r2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("r2_rsp_rdata", 64'(bus.rsp_rdata), 64'h12345678);
    chk("r2_rsp_err",   64'(bus.rsp_err),   64'd0);
    bus.PSLVERR   = 4'b0000;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("r2_done_rspv", 64'(bus.rsp_valid), 64'd0);

    // ---- 3: decode error at 0x5000 ----
    send(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    tick();                                  // N+1: RESP
    bus.cmd_valid = 1'b0;
    chk("dec_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("dec_rsp_err",   64'(bus.rsp_err),   64'd1);
    chk("dec_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("dec_psel",      64'(bus.PSEL),      64'd0);
    chk("dec_penable",   64'(bus.PENABLE),   64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("dec_done_rspv", 64'(bus.rsp_valid), 64'd0);

    // ---- 4: write completer 1 with PSLVERR, response held off 5 cycles ----
    bus.PSLVERR = 4'b0010;
    send(1'b1, 32'h0000_1008, 32'h0BADF00D, 4'h3);
    tick();                                  // N+1: SETUP
    bus.cmd_valid = 1'b0;
    chk("se_setup_psel",  64'(bus.PSEL),  64'b0010);
    chk("se_setup_pstrb", 64'(bus.PSTRB), 64'h3);
    tick();                                  // N+2: ACCESS
    tick();                                  // N+3: RESP
    bus.PSLVERR = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("se_hold_rspv",  64'(bus.rsp_valid), 64'd1);
      chk("se_hold_err",   64'(bus.rsp_err),   64'd1);
      chk("se_hold_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("se_hold_ready", 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    chk("se_pre_rspv", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("se_idle_rspv",  64'(bus.rsp_valid), 64'd0);
    chk("se_idle_ready", 64'(bus.cmd_ready), 64'd1);

    // ---- 5: reset during the second ACCESS cycle ----
    bus.PREADY = 4'b0000;
    send(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    tick();                                  // SETUP
    bus.cmd_valid = 1'b0;
    tick();                                  // ACCESS 1
    tick();                                  // ACCESS 2
    chk("rs_access_penable", 64'(bus.PENABLE), 64'd1);
    chk("rs_access_psel",    64'(bus.PSEL),    64'b1000);
    RESET = 1'b1;
    tick();
    chk("rs_psel",    64'(bus.PSEL),      64'd0);
    chk("rs_penable", 64'(bus.PENABLE),   64'd0);
    chk("rs_rspv",    64'(bus.rsp_valid), 64'd0);
    chk("rs_ready",   64'(bus.cmd_ready), 64'd0);
    chk("rs_paddr",   64'(bus.PADDR),     64'd0);
    RESET      = 1'b0;
    bus.PREADY = 4'b1111;
    tick();
    chk("rs_rel_ready", 64'(bus.cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rs_no_rsp", 64'(bus.rsp_valid), 64'd0);
      tick();
    end

    // ---- 6: completer 0 never ready ----
    bus.PREADY = 4'b1110;
    send(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    tick();                                  // SETUP
    bus.cmd_valid = 1'b0;
    tick();                                  // ACCESS 1
`ifdef APB_REQ_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("to_access_penable", 64'(bus.PENABLE), 64'd1);
      tick();
    end
    chk("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("to_rsp_err",   64'(bus.rsp_err),   64'd1);
    chk("to_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("to_psel",      64'(bus.PSEL),      64'd0);
    chk("to_penable",   64'(bus.PENABLE),   64'd0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("nt_access_penable", 64'(bus.PENABLE),   64'd1);
      chk("nt_access_rspv",    64'(bus.rsp_valid), 64'd0);
      tick();
    end
    bus.PREADY = 4'b1111;
    tick();
    chk("nt_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("nt_rsp_rdata", 64'(bus.rsp_rdata), 64'hAAAA0000);
    chk("nt_rsp_err",   64'(bus.rsp_err),   64'd0);
`endif
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("end_rspv",  64'(bus.rsp_valid), 64'd0);
    chk("end_ready", 64'(bus.cmd_ready), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
